// File: rtl/decode_stage.sv
// LC-3 decode stage: registers the fetched instruction with its control bundle, generates
// operand-bypass selects from the last two writers and inserts one bubble on a load-use hazard.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_decode,
  input  logic [15:0] instr_dout,
  input  logic [15:0] npc_in,
  output logic [15:0] ir,
  output logic [15:0] npc_out,
  output logic [5:0]  e_control,
  output logic [1:0]  w_control,
  output logic        mem_control,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2,
  output logic        valid_out,
  output logic        stall_fetch
);

  typedef enum logic [0:0] {StNormal, StBubble} state_e;

  state_e     state_q;
  logic       h1_valid_q, h1_load_q, h2_valid_q;
  logic [2:0] h1_dr_q, h2_dr_q;

  logic [5:0] dec_e;
  logic [1:0] dec_w;
  logic       dec_mem, used_1, used_2, writer, is_load, imm;
  logic [2:0] sr1, sr2, dr;
  logic       byp_alu_1, byp_alu_2, byp_mem_1, byp_mem_2, hazard;

  assign sr1 = instr_dout[8:6];
  assign sr2 = instr_dout[2:0];
  assign dr  = instr_dout[11:9];
  assign imm = instr_dout[5];

  // Control bundle layout: {alu[1:0], pcsel1[1:0], pcsel2, op2}
  always_comb begin
    dec_e   = 6'b000000;
    dec_w   = 2'b11;
    dec_mem = 1'b0;
    used_1  = 1'b0;
    used_2  = 1'b0;
    writer  = 1'b0;
    is_load = 1'b0;
    case (instr_dout[15:12])
      4'b0001: begin  // ADD
        dec_e = {2'b00, 2'b00, 1'b0, ~imm}; dec_w = 2'b00;
        used_1 = 1'b1; used_2 = ~imm; writer = 1'b1;
      end
      4'b0101: begin  // AND
        dec_e = {2'b01, 2'b00, 1'b0, ~imm}; dec_w = 2'b00;
        used_1 = 1'b1; used_2 = ~imm; writer = 1'b1;
      end
      4'b1001: begin  // NOT
        dec_e = {2'b10, 2'b00, 1'b0, 1'b0}; dec_w = 2'b00;
        used_1 = 1'b1; writer = 1'b1;
      end
      4'b0000: dec_e = {2'b00, 2'b01, 1'b1, 1'b0};  // BR
      4'b1100: begin  // JMP
        dec_e = {2'b00, 2'b11, 1'b0, 1'b0}; used_1 = 1'b1;
      end
      4'b0010, 4'b1010: begin  // LD, LDI
        dec_e = {2'b00, 2'b01, 1'b1, 1'b0}; dec_w = 2'b10;
        dec_mem = instr_dout[15]; writer = 1'b1; is_load = 1'b1;
      end
      4'b1110: begin  // LEA
        dec_e = {2'b00, 2'b01, 1'b1, 1'b0}; dec_w = 2'b01; writer = 1'b1;
      end
      4'b0011, 4'b1011: begin  // ST, STI
        dec_e = {2'b00, 2'b01, 1'b1, 1'b0}; dec_mem = instr_dout[15];
      end
      4'b0110: begin  // LDR
        dec_e = {2'b00, 2'b10, 1'b0, 1'b0}; dec_w = 2'b10;
        used_1 = 1'b1; writer = 1'b1; is_load = 1'b1;
      end
      4'b0111: begin  // STR
        dec_e = {2'b00, 2'b10, 1'b0, 1'b0}; used_1 = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    byp_alu_1 = used_1 & h1_valid_q & ~h1_load_q & (h1_dr_q == sr1);
    byp_alu_2 = used_2 & h1_valid_q & ~h1_load_q & (h1_dr_q == sr2);
    byp_mem_1 = used_1 & h2_valid_q & (h2_dr_q == sr1) & ~byp_alu_1;
    byp_mem_2 = used_2 & h2_valid_q & (h2_dr_q == sr2) & ~byp_alu_2;
    hazard    = h1_valid_q & h1_load_q &
                ((used_1 & (h1_dr_q == sr1)) | (used_2 & (h1_dr_q == sr2)));
    stall_fetch = (state_q == StNormal) & hazard & enable_decode;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StNormal;
      ir           <= 16'h0000;
      npc_out      <= 16'h0000;
      e_control    <= 6'b000000;
      w_control    <= 2'b11;
      mem_control  <= 1'b0;
      bypass_alu_1 <= 1'b0;
      bypass_alu_2 <= 1'b0;
      bypass_mem_1 <= 1'b0;
      bypass_mem_2 <= 1'b0;
      valid_out    <= 1'b0;
      h1_valid_q   <= 1'b0;
      h1_load_q    <= 1'b0;
      h1_dr_q      <= 3'd0;
      h2_valid_q   <= 1'b0;
      h2_dr_q      <= 3'd0;
    end else if (enable_decode) begin
      npc_out    <= npc_in;
      h2_valid_q <= h1_valid_q;
      h2_dr_q    <= h1_dr_q;
      if (stall_fetch) begin
        state_q      <= StBubble;
        ir           <= 16'h0000;
        e_control    <= 6'b000000;
        w_control    <= 2'b11;
        mem_control  <= 1'b0;
        bypass_alu_1 <= 1'b0;
        bypass_alu_2 <= 1'b0;
        bypass_mem_1 <= 1'b0;
        bypass_mem_2 <= 1'b0;
        valid_out    <= 1'b0;
        h1_valid_q   <= 1'b0;
        h1_load_q    <= 1'b0;
        h1_dr_q      <= 3'd0;
      end else begin
        state_q      <= StNormal;
        ir           <= instr_dout;
        e_control    <= dec_e;
        w_control    <= dec_w;
        mem_control  <= dec_mem;
        bypass_alu_1 <= byp_alu_1;
        bypass_alu_2 <= byp_alu_2;
        bypass_mem_1 <= byp_mem_1;
        bypass_mem_2 <= byp_mem_2;
        valid_out    <= 1'b1;
        h1_valid_q   <= writer;
        h1_load_q    <= is_load;
        h1_dr_q      <= dr;
      end
    end
  end

endmodule
